multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the CPU datapath: replaces per-instruction combinational decode with a state machine that steps each instruction through fetch, decode, execute, memory and write-back. It drives all datapath strobes (PC/IR write, memory access, register write, ALU operand and operation selects) and stalls on a memory ready handshake. It uses the team's opcode map: 0 R-type, 3 load, 11 store, 1 branch-equal. Any other opcode traps.

---
 rtl/multicycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU sequencer: steps each instruction through fetch/decode/exec/mem/wb,
// drives datapath strobes and selects, stalls on mem_ready, traps on unknown opcodes.
module multicycle_ctrl #(
    parameter int OPW  = 4,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            pc_src,
    output logic            ir_write,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [2:0]      alu_op,
    output logic [2:0]      state,
    output logic            illegal,
    output logic [CNTW-1:0] instr_count
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        BRANCH = 3'd5,
        TRAP   = 3'd6
    } state_t;

    localparam logic [OPW-1:0] OP_R   = OPW'(0);
    localparam logic [OPW-1:0] OP_BEQ = OPW'(1);
    localparam logic [OPW-1:0] OP_LD  = OPW'(3);
    localparam logic [OPW-1:0] OP_ST  = OPW'(11);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q;
    logic           retire;

    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            op_q        <= '0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE)
                op_q <= opcode;
            if (state_d == TRAP)
                illegal <= 1'b1;
            if (retire)
                instr_count <= instr_count + CNTW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'd0;
        // Everything stays at its default while reset is held, even though state reads FETCH.
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = 3'd2;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    alu_op    = 3'd2;
                    if (opcode == OP_R || opcode == OP_LD || opcode == OP_ST)
                        state_d = EXEC;
                    else if (opcode == OP_BEQ)
                        state_d = BRANCH;
                    else
                        state_d = TRAP;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    if (op_q == OP_R) begin
                        alu_op  = 3'd4;
                        state_d = WB;
                    end else begin
                        alu_src_b = 2'b10;
                        alu_op    = 3'd2;
                        state_d   = MEM;
                    end
                end
                MEM: begin
                    iord = 1'b1;
                    if (op_q == OP_LD)
                        mem_read = 1'b1;
                    else
                        mem_write = 1'b1;
                    if (mem_ready) begin
                        if (op_q == OP_LD) begin
                            state_d = WB;
                        end else begin
                            state_d = FETCH;
                            retire  = 1'b1;
                        end
                    end
                end
                WB: begin
                    reg_write = 1'b1;
                    if (op_q == OP_R)
                        reg_dst = 1'b1;
                    else
                        mem_to_reg = 1'b1;
                    state_d = FETCH;
                    retire  = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 3'd1;
                    pc_src    = 1'b1;
                    pc_write  = zero;
                    state_d   = FETCH;
                    retire    = 1'b1;
                end
                TRAP: state_d = TRAP;
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected traces built from the phase rules,
// a directed table, randomized instruction streams, wrap, trap and mid-instruction reset.
module tb_multicycle_ctrl;

    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    opcode = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_write, pc_src, ir_write, iord, mem_read, mem_write;
    logic          reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]    alu_src_b;
    logic [2:0]    alu_op, state;
    logic          illegal;
    logic [CW-1:0] instr_count;

    multicycle_ctrl #(.OPW(4), .CNTW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .illegal(illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Output vector layout: {pw ps irw iord mr mw rw rd m2r}_{alu_src_a}_{alu_src_b}_{alu_op}
    logic [14:0] ov;
    assign ov = {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
                 reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op};

    localparam logic [14:0] V_F0   = 15'b000010000_0_01_010;
    localparam logic [14:0] V_F1   = 15'b101010000_0_01_010;
    localparam logic [14:0] V_DEC  = 15'b000000000_0_11_010;
    localparam logic [14:0] V_EXR  = 15'b000000000_1_00_100;
    localparam logic [14:0] V_EXLS = 15'b000000000_1_10_010;
    localparam logic [14:0] V_MLD  = 15'b000110000_0_00_000;
    localparam logic [14:0] V_MST  = 15'b000101000_0_00_000;
    localparam logic [14:0] V_WBR  = 15'b000000110_0_00_000;
    localparam logic [14:0] V_WBL  = 15'b000000101_0_00_000;
    localparam logic [14:0] V_BR1  = 15'b110000000_1_00_001;
    localparam logic [14:0] V_BR0  = 15'b010000000_1_00_001;

    typedef struct {
        logic [3:0]  op;
        logic        z;
        logic        mr;
        logic [2:0]  st;
        logic [14:0] ov;
        logic        ill;
    } row_t;

    typedef struct {
        logic [3:0] op;
        logic       z;
        int         fw;
        int         mw;
        int         cyc;
    } vec_t;

    row_t tr[$];
    int   errs = 0;
    int   checks = 0;
    int   cnt = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic void add(logic [2:0] st, logic [14:0] v, logic mr, logic z,
                                logic [3:0] op, logic ill);
        row_t r;
        r.st = st; r.ov = v; r.mr = mr; r.z = z; r.op = op; r.ill = ill;
        tr.push_back(r);
    endfunction

    // Expected per-cycle trace of one instruction: fw fetch stalls, mw memory stalls.
    function automatic void build(logic [3:0] op, logic z, int fw, int mw);
        for (int i = 0; i < fw; i++) add(3'd0, V_F0, 1'b0, rb(), rop(), 1'b0);
        add(3'd0, V_F1, 1'b1, rb(), rop(), 1'b0);
        add(3'd1, V_DEC, rb(), rb(), op, 1'b0);
        case (op)
            4'd0: begin
                add(3'd2, V_EXR, rb(), rb(), rop(), 1'b0);
                add(3'd4, V_WBR, rb(), rb(), rop(), 1'b0);
            end
            4'd3, 4'd11: begin
                add(3'd2, V_EXLS, rb(), rb(), rop(), 1'b0);
                for (int i = 0; i < mw; i++)
                    add(3'd3, (op == 4'd3) ? V_MLD : V_MST, 1'b0, rb(), rop(), 1'b0);
                add(3'd3, (op == 4'd3) ? V_MLD : V_MST, 1'b1, rb(), rop(), 1'b0);
                if (op == 4'd3) add(3'd4, V_WBL, rb(), rb(), rop(), 1'b0);
            end
            4'd1: add(3'd5, z ? V_BR1 : V_BR0, rb(), z, rop(), 1'b0);
            default: for (int i = 0; i < 3; i++) add(3'd6, 15'd0, rb(), rb(), rop(), 1'b1);
        endcase
    endfunction

    task automatic apply(input string tag);
        row_t r;
        r = tr.pop_front();
        opcode = r.op; zero = r.z; mem_ready = r.mr;
        @(negedge clk);
        chk({tag, ".state"}, 32'(state), 32'(r.st));
        chk({tag, ".outs"}, 32'(ov), 32'(r.ov));
        chk({tag, ".illegal"}, 32'(illegal), 32'(r.ill));
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic z, input int fw, input int mw,
                             input string tag, output int cyc);
        int g;
        build(op, z, fw, mw);
        cyc = tr.size();
        while (tr.size() > 0) apply(tag);
        if (op == 4'd0 || op == 4'd1 || op == 4'd3 || op == 4'd11) begin
            cnt = (cnt + 1) % (1 << CW);
            g = 0;
            mem_ready = 1'b0;
            while (state != 3'd0 && g < 20) begin
                @(posedge clk); #1;
                g++; cyc++;
            end
        end
        chk({tag, ".count"}, 32'(instr_count), 32'(cnt));
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0; mem_ready = 1'b1;
        #1;
        cnt = 0;
        chk({tag, ".rst_state"}, 32'(state), 32'd0);
        chk({tag, ".rst_outs"}, 32'(ov), 32'd0);
        chk({tag, ".rst_illegal"}, 32'(illegal), 32'd0);
        chk({tag, ".rst_count"}, 32'(instr_count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t vt[8];
        int   cyc;
        int   g;
        logic [3:0] ops[4];

        vt[0] = '{op: 4'd0,  z: 1'b0, fw: 0, mw: 0, cyc: 4};
        vt[1] = '{op: 4'd3,  z: 1'b0, fw: 0, mw: 2, cyc: 7};
        vt[2] = '{op: 4'd11, z: 1'b0, fw: 0, mw: 0, cyc: 4};
        vt[3] = '{op: 4'd1,  z: 1'b1, fw: 0, mw: 0, cyc: 3};
        vt[4] = '{op: 4'd1,  z: 1'b0, fw: 0, mw: 0, cyc: 3};
        vt[5] = '{op: 4'd0,  z: 1'b0, fw: 2, mw: 0, cyc: 6};
        vt[6] = '{op: 4'd11, z: 1'b1, fw: 1, mw: 3, cyc: 8};
        vt[7] = '{op: 4'd3,  z: 1'b0, fw: 1, mw: 0, cyc: 6};
        ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd3; ops[3] = 4'd11;

        @(posedge clk); #1;
        do_reset("init");

        for (int i = 0; i < 8; i++) begin
            run_instr(vt[i].op, vt[i].z, vt[i].fw, vt[i].mw, $sformatf("vec%0d", i), cyc);
            chk($sformatf("vec%0d.cycles", i), 32'(cyc), 32'(vt[i].cyc));
        end

        for (int i = 0; i < 40; i++)
            run_instr(ops[$urandom_range(0, 3)], rb(), $urandom_range(0, 2),
                      $urandom_range(0, 2), $sformatf("rnd%0d", i), cyc);

        g = 0;
        while (cnt != (1 << CW) - 1 && g < 200) begin
            run_instr(4'd1, rb(), 0, 0, "fill", cyc);
            g++;
        end
        chk("fill.at_max", 32'(instr_count), 32'((1 << CW) - 1));
        run_instr(4'd0, 1'b0, 0, 0, "wrap", cyc);
        chk("wrap.zero", 32'(instr_count), 32'd0);
        run_instr(4'd0, 1'b0, 0, 0, "post_wrap", cyc);

        // Illegal opcode: trap, sticky flag, no retire, then reset recovery.
        run_instr(4'd7, 1'b0, 1, 0, "trap", cyc);
        add(3'd6, 15'd0, 1'b1, 1'b1, 4'd0, 1'b1);
        add(3'd6, 15'd0, 1'b1, 1'b0, 4'd3, 1'b1);
        while (tr.size() > 0) apply("trap_hold");
        chk("trap.count", 32'(instr_count), 32'(cnt));
        do_reset("trap_rst");

        run_instr(4'd11, 1'b0, 0, 0, "st", cyc);
        build(4'd3, 1'b0, 0, 3);
        for (int i = 0; i < 4; i++) apply("ld_abort");
        chk("ld_abort.in_mem", 32'(state), 32'd3);
        chk("ld_abort.held", 32'(ov), 32'(V_MLD));
        tr.delete();
        do_reset("mid_mem");
        run_instr(4'd0, 1'b0, 0, 0, "after_rst", cyc);
        chk("after_rst.cycles", 32'(cyc), 32'd4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
